if_id_fetch_queue: RTL

- Parametrised successor to the single-entry IF-to-ID pipeline register: a DEPTH-entry instruction/PC FIFO between the IF stage and ID.
- Absorbs fetch bandwidth while ID is frozen by hazard detection.
- Discards all in-flight instructions on a taken branch (flush).
- Exposes valid/ready handshakes on both sides, so IF no longer has to stall in lock-step with ID.

---
 rtl/if_id_fetch_queue_pkg.sv | 36 +++
 rtl/if_id_fetch_queue_if.sv | 42 ++++
 rtl/if_id_fetch_queue_fifo_ptr_ctrl.sv | 85 ++++++++
 rtl/if_id_fetch_queue.sv | 96 +++++++++
 4 files changed

// File: rtl/if_id_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module  : if_id_fetch_queue_pkg
// Purpose : Shared types and constants for the IF->ID fetch queue.
//           - fetch_entry_t : one queued {instruction, pc} pair
//           - FQ_NOP_INSTR  : default instruction shown to ID when empty
//           - FLUSH_DROP_W  : width of the flush-drop statistics counter
//           - sat_add_drops : saturating accumulate for that counter
// Revision: 1.0  initial release
// ============================================================================
package if_id_fetch_queue_pkg;

  localparam int unsigned FQ_WORD_LEN = 16;
  localparam int unsigned FQ_PC_LEN   = 16;
  localparam logic [FQ_WORD_LEN-1:0] FQ_NOP_INSTR = 16'h0000;
  localparam int unsigned FLUSH_DROP_W = 8;

  typedef struct packed {
    logic [FQ_WORD_LEN-1:0] instr;
    logic [FQ_PC_LEN-1:0]   pc;
  } fetch_entry_t;

  // Adds inc to acc, clamping at the all-ones value instead of wrapping.
  function automatic logic [FLUSH_DROP_W-1:0] sat_add_drops(
      input logic [FLUSH_DROP_W-1:0] acc,
      input int unsigned             inc);
    int unsigned max_v;
    int unsigned total;
    max_v = (32'd1 << FLUSH_DROP_W) - 32'd1;
    total = 32'(acc) + inc;
    if (total > max_v) return '1;
    return total[FLUSH_DROP_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module  : if_id_fetch_queue_if
// Purpose : Bundle of IF-side and ID-side handshake signals of the fetch
//           queue. 'slave' is the queue's view, 'master' is the view of the
//           surrounding pipeline (IF producer, ID consumer, hazard/branch).
// Signals : in_valid/instructionIn/pcIn/in_ready  IF-side handshake
//           flush/freeze                          pipeline control
//           instruction/pc/out_valid              head entry towards ID
//           count/flush_drops                     occupancy and statistics
// Revision: 1.0  initial release
// ============================================================================
interface if_id_fetch_queue_if #(
  parameter int WORD_LEN = 16,
  parameter int PC_LEN   = 16,
  parameter int DEPTH    = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                in_valid;
  logic [WORD_LEN-1:0] instructionIn;
  logic [PC_LEN-1:0]   pcIn;
  logic                in_ready;
  logic                flush;
  logic                freeze;
  logic [WORD_LEN-1:0] instruction;
  logic [PC_LEN-1:0]   pc;
  logic                out_valid;
  logic [CNT_W-1:0]    count;
  logic [7:0]          flush_drops;

  modport slave (
    input  in_valid, instructionIn, pcIn, flush, freeze,
    output in_ready, instruction, pc, out_valid, count, flush_drops
  );

  modport master (
    output in_valid, instructionIn, pcIn, flush, freeze,
    input  in_ready, instruction, pc, out_valid, count, flush_drops
  );
endinterface
`default_nettype wire

// File: rtl/if_id_fetch_queue_fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fifo_ptr_ctrl
// Purpose : Read/write pointers and occupancy of the fetch queue, including
//           the enqueue/dequeue qualification and flush clearing.
// Ports   : clk, rst            clock, asynchronous active-high reset
//           in_valid            IF offers an entry
//           freeze, flush       hold the head / discard everything
//           enq, deq            qualified push / pop for this cycle
//           wr_ptr, rd_ptr      storage indices
//           count, full, empty  occupancy state
// Revision: 1.0  initial release
// ============================================================================
module fifo_ptr_ctrl #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             freeze,
  input  logic             flush,
  output logic             enq,
  output logic             deq,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  always_comb begin
    full  = (count_q == CNT_W'(DEPTH));
    empty = (count_q == '0);
    // full/empty come from registered count only, so in_ready has no
    // combinational dependency on freeze or flush.
    enq   = in_valid && !full && !flush;
    deq   = !empty && !freeze && !flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointer width wraps naturally.
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(enq && !deq && (count_q == CNT_W'(DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(deq && !enq && (count_q == '0)));
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count_q <= CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/if_id_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : if_id_fetch_queue
// Purpose : DEPTH-entry instruction/PC FIFO between IF and ID. Lets IF keep
//           fetching while ID is frozen, and drops everything on a taken
//           branch.
// Ports   : clk, rst  clock, asynchronous active-high reset
//           bus       slave view of if_id_fetch_queue_if:
//                     in_valid/instructionIn/pcIn/in_ready  IF handshake
//                     flush (taken branch), freeze (hazard)
//                     instruction/pc/out_valid              head to ID
//                     count (occupancy), flush_drops (saturating stat)
// Revision: 1.0  initial release
// ============================================================================
module if_id_fetch_queue
  import if_id_fetch_queue_pkg::*;
#(
  parameter int                  WORD_LEN  = FQ_WORD_LEN,
  parameter int                  PC_LEN    = FQ_PC_LEN,
  parameter int                  DEPTH     = 4,
  parameter logic [WORD_LEN-1:0] NOP_INSTR = FQ_NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst,
  if_id_fetch_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             enq, deq, full, empty;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.in_valid),
    .freeze   (bus.freeze),
    .flush    (bus.flush),
    .enq      (enq),
    .deq      (deq),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // Payload storage is deliberately not reset; the per-entry valid bits
  // and out_valid gate it so stale or X contents never reach ID.
  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr] <= '{instr: bus.instructionIn, pc: bus.pcIn};
  end

  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [FLUSH_DROP_W-1:0] flush_drops_q, flush_drops_d;

  always_comb begin
    valid_d       = valid_q;
    flush_drops_d = flush_drops_q;
    if (bus.flush) begin
      valid_d       = '0;
      flush_drops_d = sat_add_drops(flush_drops_q, 32'(count));
    end else begin
      // wr_ptr == rd_ptr only when empty or full, and then at most one of
      // enq/deq can fire, so these two writes never collide.
      if (deq) valid_d[rd_ptr] = 1'b0;
      if (enq) valid_d[wr_ptr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      flush_drops_q <= '0;
    end else begin
      valid_q       <= valid_d;
      flush_drops_q <= flush_drops_d;
    end
  end

  logic head_live;
  assign head_live = !empty && valid_q[rd_ptr];

  assign bus.in_ready    = !full;
  assign bus.out_valid   = !empty;
  assign bus.instruction = head_live ? mem_q[rd_ptr].instr : NOP_INSTR;
  assign bus.pc          = head_live ? mem_q[rd_ptr].pc    : '0;
  assign bus.count       = count;
  assign bus.flush_drops = flush_drops_q;

endmodule
`default_nettype wire
